// File: rtl/ifu_fill_ctrl.sv
// rtl/ifu_fill_ctrl.sv - I-cache line-fill controller
// Fetches a 128-bit line as four sequential 32-bit reads; absorbs repeated misses from a stalled PC.

package ifu_pkg;
  localparam int CL_WIDTH = 128;

  typedef struct packed {
    logic        fill_requested_address_valid;
    logic [31:0] fill_requested_address;
  } t_cache2i_mem_req;

  typedef struct packed {
    logic                fill_valid;
    logic [27:0]         fill_address;
    logic [CL_WIDTH-1:0] fill_data;
  } t_i_mem2cache_rsp;
endpackage

module ifu_fill_ctrl
  import ifu_pkg::*;
#(
  parameter int CL_WIDTH       = ifu_pkg::CL_WIDTH,
  parameter int HOLDOFF_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  t_cache2i_mem_req cache2i_mem_req,
  output t_i_mem2cache_rsp i_mem2cache_rsp,
  output logic             mem_rd_req,
  output logic [31:0]      mem_rd_addr,
  input  logic             mem_rd_ready,
  input  logic             mem_rd_rsp_valid,
  input  logic [31:0]      mem_rd_rsp_data,
  output logic             fill_busy
);

  localparam int HO_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_e;

  state_e              state_q;
  logic [27:0]         line_q;
  logic [1:0]          wcnt_q;
  logic [HO_W-1:0]     holdoff_q;
  logic [CL_WIDTH-1:0] buf_q;
  logic [CL_WIDTH-1:0] buf_d;
  logic                fill_valid_q;
  logic [27:0]         fill_addr_q;
  logic [CL_WIDTH-1:0] fill_data_q;
  logic                mem_rd_req_q;
  logic [31:0]         mem_rd_addr_q;

  logic [27:0] req_line;
  logic [3:0]  unused_offset;
  logic [1:0]  wcnt_inc;
  logic        req_drop;
  logic        req_take;

  assign req_line      = cache2i_mem_req.fill_requested_address[31:4];
  assign unused_offset = cache2i_mem_req.fill_requested_address[3:0];
  assign wcnt_inc      = wcnt_q + 2'd1;

  // Repeats of the line just delivered are swallowed while the cache catches up.
  assign req_drop = (holdoff_q != '0) && (req_line == line_q);
  assign req_take = cache2i_mem_req.fill_requested_address_valid && !req_drop;

  always_comb begin
    buf_d = buf_q;
    buf_d[{wcnt_q, 5'd0} +: 32] = mem_rd_rsp_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      line_q        <= '0;
      wcnt_q        <= '0;
      holdoff_q     <= '0;
      buf_q         <= '0;
      fill_valid_q  <= 1'b0;
      fill_addr_q   <= '0;
      fill_data_q   <= '0;
      mem_rd_req_q  <= 1'b0;
      mem_rd_addr_q <= '0;
    end else begin
      if (holdoff_q != '0) holdoff_q <= holdoff_q - 1'b1;
      fill_valid_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (req_take) begin
            line_q        <= req_line;
            wcnt_q        <= 2'd0;
            holdoff_q     <= '0;
            mem_rd_req_q  <= 1'b1;
            mem_rd_addr_q <= {req_line, 2'd0, 2'b00};
            state_q       <= REQ;
          end
        end
        REQ: begin
          if (mem_rd_ready) begin
            mem_rd_req_q <= 1'b0;
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rd_rsp_valid) begin
            buf_q <= buf_d;
            if (wcnt_q == 2'd3) begin
              // Output copy only changes on delivery so consumers see stable data between pulses.
              fill_valid_q <= 1'b1;
              fill_addr_q  <= line_q;
              fill_data_q  <= buf_d;
              state_q      <= RSP;
            end else begin
              wcnt_q        <= wcnt_inc;
              mem_rd_req_q  <= 1'b1;
              mem_rd_addr_q <= {line_q, wcnt_inc, 2'b00};
              state_q       <= REQ;
            end
          end
        end
        RSP: begin
          holdoff_q <= HO_W'(HOLDOFF_CYCLES);
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_mem2cache_rsp = {fill_valid_q, fill_addr_q, fill_data_q};
  assign mem_rd_req      = mem_rd_req_q;
  assign mem_rd_addr     = mem_rd_addr_q;
  assign fill_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ifu_fill_ctrl.sv
// tb/tb_ifu_fill_ctrl.sv - directed bench for ifu_fill_ctrl
// Memory model answers word reads; expected fills are queued at request time and popped on fill_valid.

module tb_ifu_fill_ctrl;
  import ifu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  t_cache2i_mem_req req;
  t_i_mem2cache_rsp rsp;
  logic             mem_rd_req;
  logic [31:0]      mem_rd_addr;
  logic             mem_rd_ready;
  logic             mem_rd_rsp_valid;
  logic [31:0]      mem_rd_rsp_data;
  logic             fill_busy;

  ifu_fill_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .cache2i_mem_req  (req),
    .i_mem2cache_rsp  (rsp),
    .mem_rd_req       (mem_rd_req),
    .mem_rd_addr      (mem_rd_addr),
    .mem_rd_ready     (mem_rd_ready),
    .mem_rd_rsp_valid (mem_rd_rsp_valid),
    .mem_rd_rsp_data  (mem_rd_rsp_data),
    .fill_busy        (fill_busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [27:0]  line;
    logic [127:0] data;
    int           at;
  } exp_t;
  exp_t sb[$];

  int          ready_stall[4];
  int          rsp_delay[4];
  bit          pend;
  logic [31:0] pend_addr;
  int          pend_wait;
  bit          inject_spur;
  int          words_acc = 0;
  int          fills_seen = 0;
  bit          stalled_prev;
  logic [31:0] stalled_addr;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (a[31:4] == 28'h0000123) return 32'h0000_00A0 | {30'd0, a[3:2]};
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [127:0] line_data(input logic [27:0] line);
    logic [127:0] d;
    logic [1:0]   kk;
    d = '0;
    for (int k = 0; k < 4; k++) begin
      kk = 2'(k);
      d[32*k +: 32] = data_of({line, kk, 2'b00});
    end
    return d;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Memory: one-shot per-word ready stalls and response delays, driven on the falling edge.
  initial begin
    int k;
    mem_rd_ready = 1'b1; mem_rd_rsp_valid = 1'b0; mem_rd_rsp_data = '0;
    pend = 0; pend_wait = 0; inject_spur = 0; stalled_prev = 0; stalled_addr = '0; pend_addr = '0;
    for (int i = 0; i < 4; i++) begin ready_stall[i] = 0; rsp_delay[i] = 0; end
    forever begin
      @(negedge clk);
      mem_rd_rsp_valid = 1'b0;
      if (rst) pend = 0;
      else if (pend) begin
        if (pend_wait > 0) pend_wait--;
        else begin
          mem_rd_rsp_valid = 1'b1;
          mem_rd_rsp_data  = data_of(pend_addr);
          pend = 0;
        end
      end else if (inject_spur) begin
        mem_rd_rsp_valid = 1'b1;
        mem_rd_rsp_data  = 32'hDEAD_BEEF;
        inject_spur = 0;
      end
      if (mem_rd_req && stalled_prev) check("addr_stable", mem_rd_addr, stalled_addr);
      stalled_prev = 0;
      mem_rd_ready = 1'b1;
      if (mem_rd_req && !rst) begin
        k = int'(mem_rd_addr[3:2]);
        if (ready_stall[k] > 0) begin
          ready_stall[k]--;
          mem_rd_ready = 1'b0;
          stalled_prev = 1;
          stalled_addr = mem_rd_addr;
        end else begin
          pend = 1; pend_addr = mem_rd_addr;
          pend_wait = rsp_delay[k]; rsp_delay[k] = 0;
          words_acc++;
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp.fill_valid === 1'b1) begin
        fills_seen++;
        total++;
        assert (sb.size() != 0) passed++;
        else $error("FAIL unexpected_fill: observed line %0h expected none", rsp.fill_address);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("fill_line", rsp.fill_address, e.line);
          check("fill_data", rsp.fill_data, e.data);
          check("fill_cycle", cyc, e.at);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic go_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (fill_busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    check("idle_reached", fill_busy, 0);
  endtask

  task automatic start_fill(input logic [31:0] a, input int hold, input int extra, output int n);
    exp_t e;
    req.fill_requested_address_valid = 1'b1;
    req.fill_requested_address       = a;
    n = cyc;
    e.line = a[31:4]; e.data = line_data(a[31:4]); e.at = n + 9 + extra;
    sb.push_back(e);
    repeat (hold) @(negedge clk);
    req.fill_requested_address_valid = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_fill_valid"}, rsp.fill_valid, 0);
    check({tag, "_fill_address"}, rsp.fill_address, 0);
    check({tag, "_fill_data"}, rsp.fill_data, 0);
    check({tag, "_mem_rd_req"}, mem_rd_req, 0);
    check({tag, "_mem_rd_addr"}, mem_rd_addr, 0);
    check({tag, "_fill_busy"}, fill_busy, 0);
  endtask

  initial begin
    int n, m, w0, f0;
    rst = 1'b1;
    req = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single fill, zero wait
    w0 = words_acc;
    start_fill(32'h0000_1234, 1, 0, n);
    check("first_req_latency", {mem_rd_req, mem_rd_addr}, {1'b1, 32'h0000_1230});
    wait_idle();
    check("single_words", words_acc - w0, 4);
    repeat (4) @(negedge clk);

    // Stalled PC: same line held for 12 cycles
    w0 = words_acc; f0 = fills_seen;
    start_fill(32'h0000_0040, 12, 0, n);
    repeat (3) @(negedge clk);
    wait_idle();
    check("stall_fills", fills_seen - f0, 1);
    check("stall_words", words_acc - w0, 4);
    repeat (4) @(negedge clk);

    // Wait states: word 1 ready low 3 cycles, word 2 response 2 cycles late
    ready_stall[1] = 3;
    rsp_delay[2]   = 2;
    w0 = words_acc;
    start_fill(32'h0000_2000, 1, 5, n);
    wait_idle();
    check("wait_words", words_acc - w0, 4);
    repeat (4) @(negedge clk);

    // New line during holdoff
    start_fill(32'h0000_0100, 1, 0, n);
    go_to(n + 10);
    start_fill(32'h0000_0200, 1, 0, m);
    check("holdoff_newline_req", {mem_rd_req, mem_rd_addr}, {1'b1, 32'h0000_0200});
    wait_idle();
    repeat (4) @(negedge clk);

    // Reset mid-fill after word 2 returns, then a stray response
    req.fill_requested_address_valid = 1'b1;
    req.fill_requested_address       = 32'h0000_3000;
    n = cyc;
    @(negedge clk);
    req.fill_requested_address_valid = 1'b0;
    go_to(n + 7);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    inject_spur = 1;
    repeat (3) @(negedge clk);
    check("spur_busy", fill_busy, 0);
    check("spur_fill_data", rsp.fill_data, 0);
    w0 = words_acc;
    start_fill(32'h0000_0080, 1, 0, n);
    wait_idle();
    check("post_reset_words", words_acc - w0, 4);
    repeat (4) @(negedge clk);

    // Busy ignore: 0x300 arrives while 0x100 is filling
    w0 = words_acc; f0 = fills_seen;
    start_fill(32'h0000_0100, 1, 0, n);
    go_to(n + 3);
    req.fill_requested_address_valid = 1'b1;
    req.fill_requested_address       = 32'h0000_0300;
    repeat (2) @(negedge clk);
    req.fill_requested_address_valid = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);
    check("busy_fills", fills_seen - f0, 1);
    check("busy_words", words_acc - w0, 4);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
